// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL CPU write path: register bases, rhythm bit
// positions and the strobe kinds driven towards the operator/channel register file.
package jtopl_pkg;

    localparam logic [7:0] REG_TEST  = 8'h01;
    localparam logic [7:0] REG_CSM   = 8'h08;
    localparam logic [7:0] REG_MULT  = 8'h20;
    localparam logic [7:0] REG_KSLTL = 8'h40;
    localparam logic [7:0] REG_ARDR  = 8'h60;
    localparam logic [7:0] REG_SLRR  = 8'h80;
    localparam logic [7:0] REG_FNLO  = 8'hA0;
    localparam logic [7:0] REG_FNHI  = 8'hB0;
    localparam logic [7:0] REG_RHY   = 8'hBD;
    localparam logic [7:0] REG_FBCON = 8'hC0;
    localparam logic [7:0] REG_WAV   = 8'hE0;

    localparam int BD  = 4;
    localparam int SD  = 3;
    localparam int TOM = 2;
    localparam int TC  = 1;
    localparam int HH  = 0;

    localparam int NUM_KINDS = 8;

    typedef enum logic [2:0] {
        KIND_MULT,
        KIND_KSLTL,
        KIND_ARDR,
        KIND_SLRR,
        KIND_WAV,
        KIND_FNLO,
        KIND_FNHI,
        KIND_FBCON
    } kind_t;

    // Channels 0..8 are laid out as three groups of three.
    function automatic logic [4:0] ch_sel(input logic [3:0] ch);
        logic [1:0] g;
        logic [2:0] s;
        g = 2'(ch / 4'd3);
        s = 3'(ch % 4'd3);
        return {g, s};
    endfunction

endpackage

// File: rtl/jtopl_wrdec_map.sv
// Combinational register-index decoder: index -> strobe kind plus group/subslot.
// Global registers (0x01, 0x08, 0xBD) are not reported here.
module jtopl_wrdec_map
    import jtopl_pkg::*;
#(
    parameter int OPL_TYPE = 1
) (
    input  logic [7:0] index,
    output kind_t      kind,
    output logic [1:0] group,
    output logic [2:0] sub,
    output logic       valid
);

    logic op_ok;
    logic ch_ok;

    // Operator offsets skip 6,7 in each group of 8 and only three groups exist.
    assign op_ok = (index[2:0] <= 3'd5) && (index[4:3] <= 2'd2);
    assign ch_ok = (index[3:0] <= 4'd8);

    always_comb begin
        kind  = KIND_MULT;
        group = 2'd0;
        sub   = 3'd0;
        valid = 1'b0;
        case (index[7:5])
            3'b001, 3'b010, 3'b011, 3'b100, 3'b111: begin
                group = index[4:3];
                sub   = index[2:0];
                valid = op_ok;
                case (index[7:5])
                    3'b001:  kind = KIND_MULT;
                    3'b010:  kind = KIND_KSLTL;
                    3'b011:  kind = KIND_ARDR;
                    3'b100:  kind = KIND_SLRR;
                    default: begin
                        kind  = KIND_WAV;
                        valid = op_ok && (OPL_TYPE != 1);
                    end
                endcase
            end
            3'b101, 3'b110: begin
                {group, sub} = ch_sel(index[3:0]);
                case (index[7:4])
                    4'hA: begin
                        kind  = KIND_FNLO;
                        valid = ch_ok;
                    end
                    4'hB: begin
                        kind  = KIND_FNHI;
                        valid = ch_ok;
                    end
                    4'hC: begin
                        kind  = KIND_FBCON;
                        valid = ch_ok;
                    end
                    default: valid = 1'b0;
                endcase
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/jtopl_wrdec.sv
// CPU write decoder/sequencer: latches global registers and holds one update
// strobe for HOLD_LEN slot ticks so the register file sweeps every slot.
module jtopl_wrdec
    import jtopl_pkg::*;
#(
    parameter int OPL_TYPE = 1,
    parameter int HOLD_LEN = 21
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       write,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       busy,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       wave_mode,
    output logic       note_sel
);

    localparam int CNT_W = $clog2(HOLD_LEN + 1);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    kind_t              kind_reg, kind_next;
    logic [1:0]         group_reg, group_next;
    logic [2:0]         sub_reg, sub_next;
    logic [7:0]         index_reg, index_next;
    logic [7:0]         dout_reg, dout_next;
    logic               write_reg, write_next;
    logic               rhy_en_reg, rhy_en_next;
    logic [4:0]         rhy_kon_reg, rhy_kon_next;
    logic               am_reg, am_next;
    logic               vib_reg, vib_next;
    logic               wave_reg, wave_next;
    logic               note_reg, note_next;
    logic               wr_prev_reg;

    kind_t      map_kind;
    logic [1:0] map_group;
    logic [2:0] map_sub;
    logic       map_valid;

    logic accept, idx_wr, dat_wr, strobe_wr, rhy_wr, test_wr, csm_wr;

    jtopl_wrdec_map #(.OPL_TYPE(OPL_TYPE)) u_map (
        .index (index_reg),
        .kind  (map_kind),
        .group (map_group),
        .sub   (map_sub),
        .valid (map_valid)
    );

    // One action per CPU strobe: only the clk where wr_n falls counts.
    assign accept    = !cs_n && !wr_n && wr_prev_reg;
    assign idx_wr    = accept && !addr;
    assign dat_wr    = accept && addr;
    assign strobe_wr = dat_wr && map_valid;
    assign rhy_wr    = dat_wr && (index_reg == REG_RHY);
    assign test_wr   = dat_wr && (index_reg == REG_TEST);
    assign csm_wr    = dat_wr && (index_reg == REG_CSM);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        kind_next    = kind_reg;
        group_next   = group_reg;
        sub_next     = sub_reg;
        index_next   = index_reg;
        dout_next    = dout_reg;
        write_next   = 1'b0;
        rhy_en_next  = rhy_en_reg;
        rhy_kon_next = rhy_kon_reg;
        am_next      = am_reg;
        vib_next     = vib_reg;
        wave_next    = wave_reg;
        note_next    = note_reg;

        if (idx_wr)
            index_next = din;
        if (strobe_wr || rhy_wr || test_wr || csm_wr)
            dout_next = din;
        if (rhy_wr) begin
            am_next      = din[7];
            vib_next     = din[6];
            rhy_en_next  = din[5];
            rhy_kon_next = din[4:0];
        end
        if (test_wr)
            wave_next = (OPL_TYPE != 1) ? din[5] : 1'b0;
        if (csm_wr)
            note_next = din[6];

        case (state_reg)
            ST_IDLE: begin
                if (strobe_wr) begin
                    state_next = ST_HOLD;
                    cnt_next   = CNT_W'(HOLD_LEN);
                    kind_next  = map_kind;
                    group_next = map_group;
                    sub_next   = map_sub;
                    write_next = 1'b1;
                end
            end
            ST_HOLD: begin
                // A new target restarts the sweep; otherwise count slot ticks down.
                if (strobe_wr) begin
                    cnt_next   = CNT_W'(HOLD_LEN);
                    kind_next  = map_kind;
                    group_next = map_group;
                    sub_next   = map_sub;
                    write_next = 1'b1;
                end else if (cen) begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            kind_reg    <= KIND_MULT;
            group_reg   <= 2'd0;
            sub_reg     <= 3'd0;
            index_reg   <= 8'd0;
            dout_reg    <= 8'd0;
            write_reg   <= 1'b0;
            rhy_en_reg  <= 1'b0;
            rhy_kon_reg <= 5'd0;
            am_reg      <= 1'b0;
            vib_reg     <= 1'b0;
            wave_reg    <= 1'b0;
            note_reg    <= 1'b0;
            wr_prev_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            kind_reg    <= kind_next;
            group_reg   <= group_next;
            sub_reg     <= sub_next;
            index_reg   <= index_next;
            dout_reg    <= dout_next;
            write_reg   <= write_next;
            rhy_en_reg  <= rhy_en_next;
            rhy_kon_reg <= rhy_kon_next;
            am_reg      <= am_next;
            vib_reg     <= vib_next;
            wave_reg    <= wave_next;
            note_reg    <= note_next;
            wr_prev_reg <= wr_n;
        end
    end

    logic [NUM_KINDS-1:0] up_vec;

    generate
        for (genvar gi = 0; gi < NUM_KINDS; gi++) begin : g_up
            assign up_vec[gi] = (state_reg == ST_HOLD) && (kind_reg == kind_t'(3'(gi)));
        end
    endgenerate

    assign up_mult   = up_vec[KIND_MULT];
    assign up_ksl_tl = up_vec[KIND_KSLTL];
    assign up_ar_dr  = up_vec[KIND_ARDR];
    assign up_sl_rr  = up_vec[KIND_SLRR];
    assign up_wav    = up_vec[KIND_WAV];
    assign up_fnumlo = up_vec[KIND_FNLO];
    assign up_fnumhi = up_vec[KIND_FNHI];
    assign up_fbcon  = up_vec[KIND_FBCON];

    assign busy      = (state_reg == ST_HOLD);
    assign dout      = dout_reg;
    assign write     = write_reg;
    assign sel_group = group_reg;
    assign sel_sub   = sub_reg;
    assign rhy_en    = rhy_en_reg;
    assign rhy_kon   = rhy_kon_reg;
    assign am_dep    = am_reg;
    assign vib_dep   = vib_reg;
    assign wave_mode = wave_reg;
    assign note_sel  = note_reg;

endmodule

// File: tb/tb_jtopl_wrdec.sv
// Directed bench for jtopl_wrdec: an OPL instance (a_*) and an OPL2 instance (b_*)
// share one CPU bus; strobe vectors are ordered {fbcon,fnumhi,fnumlo,wav,sl_rr,ar_dr,ksl_tl,mult}.
module tb_jtopl_wrdec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       addr = 1'b0;
    logic [7:0] din = 8'd0;

    logic [7:0] a_dout, b_dout;
    logic       a_write, b_write;
    logic [1:0] a_sel_group, b_sel_group;
    logic [2:0] a_sel_sub, b_sel_sub;
    logic       a_up_mult, a_up_ksl_tl, a_up_ar_dr, a_up_sl_rr, a_up_wav, a_up_fnumlo, a_up_fnumhi, a_up_fbcon;
    logic       b_up_mult, b_up_ksl_tl, b_up_ar_dr, b_up_sl_rr, b_up_wav, b_up_fnumlo, b_up_fnumhi, b_up_fbcon;
    logic       a_busy, b_busy;
    logic       a_rhy_en, b_rhy_en;
    logic [4:0] a_rhy_kon, b_rhy_kon;
    logic       a_am_dep, b_am_dep, a_vib_dep, b_vib_dep;
    logic       a_wave_mode, b_wave_mode, a_note_sel, b_note_sel;

    logic [7:0] a_up, b_up;
    assign a_up = {a_up_fbcon, a_up_fnumhi, a_up_fnumlo, a_up_wav, a_up_sl_rr, a_up_ar_dr, a_up_ksl_tl, a_up_mult};
    assign b_up = {b_up_fbcon, b_up_fnumhi, b_up_fnumlo, b_up_wav, b_up_sl_rr, b_up_ar_dr, b_up_ksl_tl, b_up_mult};

    always #5 clk = ~clk;

    jtopl_wrdec #(.OPL_TYPE(1), .HOLD_LEN(21)) dut_a (
        .rst(rst), .clk(clk), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
        .dout(a_dout), .write(a_write), .sel_group(a_sel_group), .sel_sub(a_sel_sub),
        .up_mult(a_up_mult), .up_ksl_tl(a_up_ksl_tl), .up_ar_dr(a_up_ar_dr), .up_sl_rr(a_up_sl_rr),
        .up_wav(a_up_wav), .up_fnumlo(a_up_fnumlo), .up_fnumhi(a_up_fnumhi), .up_fbcon(a_up_fbcon),
        .busy(a_busy), .rhy_en(a_rhy_en), .rhy_kon(a_rhy_kon), .am_dep(a_am_dep), .vib_dep(a_vib_dep),
        .wave_mode(a_wave_mode), .note_sel(a_note_sel)
    );

    jtopl_wrdec #(.OPL_TYPE(2), .HOLD_LEN(21)) dut_b (
        .rst(rst), .clk(clk), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
        .dout(b_dout), .write(b_write), .sel_group(b_sel_group), .sel_sub(b_sel_sub),
        .up_mult(b_up_mult), .up_ksl_tl(b_up_ksl_tl), .up_ar_dr(b_up_ar_dr), .up_sl_rr(b_up_sl_rr),
        .up_wav(b_up_wav), .up_fnumlo(b_up_fnumlo), .up_fnumhi(b_up_fnumhi), .up_fbcon(b_up_fbcon),
        .busy(b_busy), .rhy_en(b_rhy_en), .rhy_kon(b_rhy_kon), .am_dep(b_am_dep), .vib_dep(b_vib_dep),
        .wave_mode(b_wave_mode), .note_sel(b_note_sel)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         cen_seen = 0;
    logic [1:0] phase = 2'd0;
    logic       cen_on = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clk: count the cen that was just sampled, then drive the next inputs.
    task automatic cycle(input logic c, input logic w, input logic a, input logic [7:0] d);
        @(negedge clk);
        if (cen) cen_seen++;
        phase = phase + 2'd1;
        cen   = cen_on && (phase == 2'd0);
        cs_n  = c;
        wr_n  = w;
        addr  = a;
        din   = d;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        cycle(1'b0, 1'b0, a, d);
        cycle(1'b1, 1'b1, a, d);
        $display("wr addr=%0d din=0x%02h : write=%0d busy=%0d up=0x%02h grp=%0d sub=%0d dout=0x%02h",
                 a, d, a_write, a_busy, a_up, a_sel_group, a_sel_sub, a_dout);
    endtask

    task automatic wr_reg(input logic [7:0] idx, input logic [7:0] d);
        wr(1'b0, idx);
        wr(1'b1, d);
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while (a_busy === 1'b1 && guard < 500) begin
            cycle(1'b1, 1'b1, 1'b0, 8'd0);
            guard++;
        end
        chk({tag, "_idle"}, 32'(a_busy), 0);
    endtask

    initial begin
        int base;
        int pulses;

        // Reset
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 8'd0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_up", 32'(a_up), 0);
        chk("rst_dout", 32'(a_dout), 0);
        chk("rst_write", 32'(a_write), 0);
        chk("rst_sel", 32'({a_sel_group, a_sel_sub}), 0);
        chk("rst_rhy", 32'({a_am_dep, a_vib_dep, a_rhy_en, a_rhy_kon}), 0);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 8'd0);

        // 0x33 <- 0x5A : mult, group 2 sub 3, held 21 cen ticks
        wr_reg(8'h33, 8'h5A);
        base = cen_seen;
        chk("mult_write", 32'(a_write), 1);
        chk("mult_up", 32'(a_up), 'h01);
        chk("mult_group", 32'(a_sel_group), 2);
        chk("mult_sub", 32'(a_sel_sub), 3);
        chk("mult_dout", 32'(a_dout), 'h5A);
        chk("mult_busy", 32'(a_busy), 1);
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        chk("mult_write_end", 32'(a_write), 0);
        wait_idle("mult");
        chk("mult_ticks", cen_seen - base, 21);
        chk("mult_up_clear", 32'(a_up), 0);

        // 0xA7 <- 0x12 : fnumlo, channel 7
        wr_reg(8'hA7, 8'h12);
        chk("fnlo_up", 32'(a_up), 'h20);
        chk("fnlo_sel", 32'({a_sel_group, a_sel_sub}), 32'({2'd2, 3'd1}));
        wait_idle("fnlo");

        // Ignored writes: channel 9, operator offset 6, operator group 3
        wr_reg(8'hC9, 8'hFF);
        chk("ch9_write", 32'(a_write), 0);
        chk("ch9_up", 32'(a_up), 0);
        chk("ch9_dout", 32'(a_dout), 'h12);
        wr_reg(8'h26, 8'h01);
        chk("off6_write", 32'(a_write), 0);
        chk("off6_busy", 32'(a_busy), 0);
        wr_reg(8'h38, 8'h01);
        chk("grp3_write", 32'(a_write), 0);
        chk("grp3_busy", 32'(a_busy), 0);

        // Rhythm register during a ksl_tl hold
        wr_reg(8'h41, 8'h77);
        base = cen_seen;
        chk("ksl_up", 32'(a_up), 'h02);
        chk("ksl_sel", 32'({a_sel_group, a_sel_sub}), 32'({2'd0, 3'd1}));
        wr_reg(8'hBD, 8'h3F);
        chk("rhy_en", 32'(a_rhy_en), 1);
        chk("rhy_kon", 32'(a_rhy_kon), 'h1F);
        chk("rhy_dep", 32'({a_am_dep, a_vib_dep}), 0);
        chk("rhy_up_held", 32'(a_up), 'h02);
        chk("rhy_busy_held", 32'(a_busy), 1);
        wait_idle("rhy");
        chk("rhy_ticks", cen_seen - base, 21);
        wr_reg(8'hBD, 8'hC0);
        chk("dep_bits", 32'({a_am_dep, a_vib_dep, a_rhy_en, a_rhy_kon}), 32'({2'b11, 1'b0, 5'd0}));
        chk("dep_busy", 32'(a_busy), 0);

        // Replacement during hold at cnt=10, then a cen freeze
        wr_reg(8'h42, 8'h11);
        base = cen_seen;
        wr(1'b0, 8'hB4);
        chk("idxhold_up", 32'(a_up), 'h02);
        chk("idxhold_busy", 32'(a_busy), 1);
        while (cen_seen - base < 11) cycle(1'b1, 1'b1, 1'b0, 8'd0);
        wr(1'b1, 8'h2C);
        base = cen_seen;
        chk("repl_write", 32'(a_write), 1);
        chk("repl_up", 32'(a_up), 'h40);
        chk("repl_sel", 32'({a_sel_group, a_sel_sub}), 32'({2'd1, 3'd1}));
        chk("repl_dout", 32'(a_dout), 'h2C);
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 8'd0);
        cen_on = 1'b0;
        repeat (40) cycle(1'b1, 1'b1, 1'b0, 8'd0);
        chk("freeze_busy", 32'(a_busy), 1);
        cen_on = 1'b1;
        wait_idle("repl");
        chk("repl_ticks", cen_seen - base, 21);

        // wr_n held low for several clks: exactly one accepted write
        wr(1'b0, 8'h20);
        pulses = 0;
        cycle(1'b0, 1'b0, 1'b1, 8'h99);
        repeat (4) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h99);
            pulses += 32'(a_write);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        pulses += 32'(a_write);
        $display("held wr_n low: write pulses=%0d up=0x%02h", pulses, a_up);
        chk("edge_pulses", pulses, 1);
        chk("edge_up", 32'(a_up), 'h01);
        wait_idle("edge");

        // cs_n high: data strobe not accepted
        cycle(1'b1, 1'b0, 1'b1, 8'h55);
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        chk("csn_busy", 32'(a_busy), 0);
        chk("csn_dout", 32'(a_dout), 'h99);

        // OPL vs OPL2: waveform range and 0x01 bit5
        wr_reg(8'hE0, 8'h20);
        chk("wav_a_busy", 32'(a_busy), 0);
        chk("wav_a_up", 32'(a_up), 0);
        chk("wav_b_up", 32'(b_up), 'h10);
        chk("wav_b_busy", 32'(b_busy), 1);
        wr_reg(8'h01, 8'h20);
        chk("wave_a", 32'(a_wave_mode), 0);
        chk("wave_b", 32'(b_wave_mode), 1);
        wr_reg(8'h08, 8'h40);
        chk("note_sel", 32'(a_note_sel), 1);

        // Reset in the middle of the OPL2 hold
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        $display("mid-hold reset: b_busy=%0d b_up=0x%02h b_wave=%0d b_note=%0d b_am=%0d",
                 b_busy, b_up, b_wave_mode, b_note_sel, b_am_dep);
        chk("mrst_busy", 32'(b_busy), 0);
        chk("mrst_up", 32'(b_up), 0);
        chk("mrst_globals", 32'({b_wave_mode, b_note_sel, b_am_dep, b_vib_dep, b_rhy_en}), 0);
        chk("mrst_dout", 32'(b_dout), 0);
        rst = 1'b0;
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
